// File: rtl/npc_seq_pkg.sv
// rtl/npc_seq_pkg.sv - shared state encoding and decode-select encodings for the NPC sequencer
package npc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IF_REQ,
    ST_IF_WAIT,
    ST_EXEC,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALT
  } npc_state_e;

  localparam logic [1:0] NPC_SEL_SNPC   = 2'b00;
  localparam logic [1:0] NPC_SEL_DNPC   = 2'b01;
  localparam logic [1:0] NPC_SEL_JALR   = 2'b10;
  localparam logic [1:0] NPC_SEL_BRANCH = 2'b11;

  localparam logic [1:0] WDATA_SEL_ALU  = 2'b00;
  localparam logic [1:0] WDATA_SEL_SNPC = 2'b01;
  localparam logic [1:0] WDATA_SEL_DNPC = 2'b10;
  localparam logic [1:0] WDATA_SEL_LOAD = 2'b11;

  localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/npc_seq_nextpc.sv
// rtl/npc_seq_nextpc.sv - combinational next-PC and register write-data selection
module npc_seq_nextpc
  import npc_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] ldata,
  input  logic [1:0]      npc_sel,
  input  logic [1:0]      wdata_sel,
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] snpc;
  logic [XLEN-1:0] dnpc;

  // Both adders wrap modulo 2^XLEN.
  assign snpc = pc + XLEN'(4);
  assign dnpc = pc + imm;

  always_comb begin
    npc = snpc;
    unique case (npc_sel)
      NPC_SEL_SNPC:   npc = snpc;
      NPC_SEL_DNPC:   npc = dnpc;
      NPC_SEL_JALR:   npc = alu_result & ~XLEN'(1);
      NPC_SEL_BRANCH: npc = alu_zero ? snpc : dnpc;
      default:        npc = snpc;
    endcase
  end

  always_comb begin
    wdata = alu_result;
    unique case (wdata_sel)
      WDATA_SEL_ALU:  wdata = alu_result;
      WDATA_SEL_SNPC: wdata = snpc;
      WDATA_SEL_DNPC: wdata = dnpc;
      WDATA_SEL_LOAD: wdata = ldata;
      default:        wdata = alu_result;
    endcase
  end

endmodule

// File: rtl/npc_mc_seq.sv
// rtl/npc_mc_seq.sv - multi-cycle fetch/execute/memory/writeback sequencer for the NPC core
// Optional NPC_SEQ_MISALIGN_EN: halt with misalign_err instead of aligning the next PC.
module npc_mc_seq
  import npc_seq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(NPC_RESET_PC),
  parameter int              ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_addr,
  input  logic            ifu_resp_valid,
  input  logic [ILEN-1:0] ifu_resp_inst,
  output logic [ILEN-1:0] inst,
  input  logic [1:0]      dec_npc_sel,
  input  logic [1:0]      dec_wdata_sel,
  input  logic            dec_reg_wen,
  input  logic            dec_mem_ren,
  input  logic            dec_mem_wen,
  input  logic            dec_halt,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  output logic            lsu_req_wen,
  input  logic            lsu_resp_valid,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            reg_wen,
  output logic [XLEN-1:0] reg_wdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
`ifdef NPC_SEQ_MISALIGN_EN
  output logic            misalign_err,
`endif
  output logic            halt
);

  npc_state_e      state;
  npc_state_e      state_d;
  logic [XLEN-1:0] ldata;
  logic [XLEN-1:0] npc_raw;
  logic [XLEN-1:0] pc_d;
  logic            pc_we;
  logic            npc_bad;

  npc_seq_nextpc #(.XLEN(XLEN)) u_nextpc (
    .pc         (pc),
    .imm        (imm),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .ldata      (ldata),
    .npc_sel    (dec_npc_sel),
    .wdata_sel  (dec_wdata_sel),
    .npc        (npc_raw),
    .wdata      (reg_wdata)
  );

`ifdef NPC_SEQ_MISALIGN_EN
  assign npc_bad = |npc_raw[1:0];
  assign pc_d    = npc_raw;
`else
  assign npc_bad = 1'b0;
  assign pc_d    = npc_raw & ~XLEN'(3);
`endif

  assign ifu_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IF_REQ;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d       = state;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    reg_wen       = 1'b0;
    retire        = 1'b0;
    pc_we         = 1'b0;
    halt          = 1'b0;
    unique case (state)
      ST_IF_REQ: begin
        ifu_req_valid = 1'b1;
        if (ifu_req_ready) state_d = ST_IF_WAIT;
      end
      ST_IF_WAIT: begin
        if (ifu_resp_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (dec_mem_ren || dec_mem_wen) ? ST_MEM_REQ : ST_WB;
      end
      ST_MEM_REQ: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = dec_mem_wen;
        if (lsu_req_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (lsu_resp_valid) state_d = ST_WB;
      end
      ST_WB: begin
        reg_wen = dec_reg_wen;
        retire  = 1'b1;
        if (npc_bad) begin
          state_d = ST_HALT;
        end else begin
          pc_we   = 1'b1;
          state_d = dec_halt ? ST_HALT : ST_IF_REQ;
        end
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      default: state_d = ST_IF_REQ;
    endcase
  end

  // inst, pc and ldata only move at state boundaries so decode sees stable inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      inst  <= '0;
      ldata <= '0;
    end else begin
      if (state == ST_IF_WAIT && ifu_resp_valid) inst <= ifu_resp_inst;
      if (state == ST_MEM_WAIT && lsu_resp_valid && !dec_mem_wen) ldata <= lsu_rdata;
      if (pc_we) pc <= pc_d;
    end
  end

`ifdef NPC_SEQ_MISALIGN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_err <= 1'b0;
    end else if (state == ST_WB && npc_bad) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_mc_seq.sv
// tb/tb_npc_mc_seq.sv - self-checking bench for npc_mc_seq with IFU/LSU responders and a retire scoreboard
module tb_npc_mc_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_resp_inst, inst;
  logic [1:0]  dec_npc_sel, dec_wdata_sel;
  logic        dec_reg_wen, dec_mem_ren, dec_mem_wen, dec_halt;
  logic [31:0] imm, alu_result;
  logic        alu_zero;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        reg_wen;
  logic [31:0] reg_wdata, pc;
  logic        retire, halt;
`ifdef NPC_SEQ_MISALIGN_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  npc_mc_seq #(.XLEN(32), .RESET_PC(32'h8000_0000), .ILEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_inst  (ifu_resp_inst),
    .inst           (inst),
    .dec_npc_sel    (dec_npc_sel),
    .dec_wdata_sel  (dec_wdata_sel),
    .dec_reg_wen    (dec_reg_wen),
    .dec_mem_ren    (dec_mem_ren),
    .dec_mem_wen    (dec_mem_wen),
    .dec_halt       (dec_halt),
    .imm            (imm),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .reg_wen        (reg_wen),
    .reg_wdata      (reg_wdata),
    .pc             (pc),
    .retire         (retire),
`ifdef NPC_SEQ_MISALIGN_EN
    .misalign_err   (misalign_err),
`endif
    .halt           (halt)
  );

  typedef struct {
    logic [1:0]  npc_sel, wsel;
    logic        wen, mren, mwen, hlt;
    logic [31:0] imm, alu;
    logic        zero;
    logic [31:0] rdata, iword;
    int          ifu_rdy, ifu_lat, lsu_rdy, lsu_lat;
    logic [31:0] e_addr, e_wdata, e_pc;
    logic        e_lwen;
    int          e_cyc;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [31:0] wdata, pc, iword;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] npc_sel, input logic [1:0] wsel, input logic wen,
                               input logic mren, input logic mwen, input logic hlt,
                               input logic [31:0] immv, input logic [31:0] alu, input logic zero,
                               input logic [31:0] rdata, input logic [31:0] iword,
                               input int ifu_rdy, input int ifu_lat, input int lsu_rdy, input int lsu_lat,
                               input logic [31:0] e_addr, input logic [31:0] e_wdata,
                               input logic [31:0] e_pc, input logic e_lwen, input int e_cyc);
    vec_t v;
    v.npc_sel = npc_sel; v.wsel = wsel; v.wen = wen; v.mren = mren; v.mwen = mwen; v.hlt = hlt;
    v.imm = immv; v.alu = alu; v.zero = zero; v.rdata = rdata; v.iword = iword;
    v.ifu_rdy = ifu_rdy; v.ifu_lat = ifu_lat; v.lsu_rdy = lsu_rdy; v.lsu_lat = lsu_lat;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_pc = e_pc; v.e_lwen = e_lwen; v.e_cyc = e_cyc;
    return v;
  endfunction

  // Acts as IFU and LSU for one instruction; entered and left on a negedge with the DUT in IF_REQ.
  task automatic run_inst(input vec_t v);
    int   vcnt = 0;
    int   lcnt = 0;
    int   acc = -1;
    int   lacc = -1;
    bit   done = 0;
    exp_t e;
    exp_t got;
    dec_npc_sel = v.npc_sel; dec_wdata_sel = v.wsel; dec_reg_wen = v.wen;
    dec_mem_ren = v.mren; dec_mem_wen = v.mwen; dec_halt = v.hlt;
    imm = v.imm; alu_result = v.alu; alu_zero = v.zero; lsu_rdata = v.rdata;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      ifu_req_ready = 0; ifu_resp_valid = 0; lsu_req_ready = 0; lsu_resp_valid = 0;
      if (ifu_req_valid) begin
        vcnt++;
        if (vcnt > v.ifu_rdy) begin
          ifu_req_ready = 1;
          acc = cyc;
          chk("ifu_addr", ifu_addr, v.e_addr);
          e.wen = v.wen; e.wdata = v.e_wdata; e.pc = v.e_pc; e.iword = v.iword; e.cyc = v.e_cyc;
          sb.push_back(e);
        end
      end
      if (acc > 0 && cyc == acc + v.ifu_lat) begin
        ifu_resp_valid = 1;
        ifu_resp_inst = v.iword;
      end
      if (lsu_req_valid) begin
        lcnt++;
        if (lcnt > v.lsu_rdy) begin
          lsu_req_ready = 1;
          lacc = cyc;
          chk("lsu_req_wen", lsu_req_wen, v.e_lwen);
        end
      end
      if (lacc > 0 && cyc == lacc + v.lsu_lat) lsu_resp_valid = 1;
      if (retire) begin
        done = 1;
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          got = sb.pop_front();
          chk("retire_cycle", cyc, got.cyc);
          chk("reg_wen", reg_wen, got.wen);
          if (got.wen) chk("reg_wdata", reg_wdata, got.wdata);
          chk("inst", inst, got.iword);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    ifu_req_ready = 0; ifu_resp_valid = 0; lsu_req_ready = 0; lsu_resp_valid = 0;
    if (!done) begin
      chk("retire_timeout", 0, 1);
    end else begin
      chk("pc_after_wb", pc, got.pc);
      chk("retire_pulse_len", retire, 0);
      chk("ifu_req_cycles", vcnt, v.ifu_rdy + 1);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = mkv(2'b00, 2'b00, 1, 0, 0, 0, 32'h0, 32'h5, 0, 32'h0, 32'h0050_0093, 0, 1, 0, 1, 32'h8000_0000, 32'h5, 32'h8000_0004, 0, 4);
    vecs[1] = mkv(2'b00, 2'b00, 1, 0, 0, 0, 32'h0, 32'h5, 0, 32'h0, 32'h0050_0093, 3, 3, 0, 1, 32'h8000_0004, 32'h5, 32'h8000_0008, 0, 9);
    vecs[2] = mkv(2'b00, 2'b11, 1, 1, 0, 0, 32'h0, 32'h8000_1000, 0, 32'hDEAD_BEEF, 32'h0005_2283, 0, 1, 0, 2, 32'h8000_0008, 32'hDEAD_BEEF, 32'h8000_000C, 0, 7);
    vecs[3] = mkv(2'b00, 2'b00, 0, 1, 1, 0, 32'h0, 32'h8000_1004, 0, 32'h1234_5678, 32'h0055_2223, 0, 1, 1, 1, 32'h8000_000C, 32'h0, 32'h8000_0010, 1, 7);
    vecs[4] = mkv(2'b11, 2'b00, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h1, 0, 32'h0, 32'hFE00_08E3, 0, 1, 0, 1, 32'h8000_0010, 32'h0, 32'h8000_0000, 0, 4);
    vecs[5] = mkv(2'b01, 2'b01, 1, 0, 0, 0, 32'h10, 32'h0, 0, 32'h0, 32'h0100_00EF, 0, 1, 0, 1, 32'h8000_0000, 32'h8000_0004, 32'h8000_0010, 0, 4);
    vecs[6] = mkv(2'b11, 2'b00, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 1, 32'h0, 32'hFE00_08E3, 0, 1, 0, 1, 32'h8000_0010, 32'h0, 32'h8000_0014, 0, 4);
    vecs[7] = mkv(2'b00, 2'b10, 1, 0, 0, 0, 32'h8000_0000, 32'h0, 0, 32'h0, 32'h8000_0117, 0, 1, 0, 1, 32'h8000_0014, 32'h0000_0014, 32'h8000_0018, 0, 4);
    vecs[8] = mkv(2'b00, 2'b11, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0000_0013, 0, 1, 0, 1, 32'h8000_0018, 32'hDEAD_BEEF, 32'h8000_001C, 0, 4);
`ifdef NPC_SEQ_MISALIGN_EN
    vecs[9] = mkv(2'b10, 2'b01, 1, 0, 0, 0, 32'h0, 32'h8000_0103, 0, 32'h0, 32'h0000_80E7, 0, 1, 0, 1, 32'h8000_001C, 32'h8000_0020, 32'h8000_001C, 0, 4);
`else
    vecs[9] = mkv(2'b10, 2'b01, 1, 0, 0, 0, 32'h0, 32'h8000_0103, 0, 32'h0, 32'h0000_80E7, 0, 1, 0, 1, 32'h8000_001C, 32'h8000_0020, 32'h8000_0100, 0, 4);
`endif

    rst = 0;
    ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_inst = 0;
    dec_npc_sel = 0; dec_wdata_sel = 0; dec_reg_wen = 0; dec_mem_ren = 0; dec_mem_wen = 0; dec_halt = 0;
    imm = 0; alu_result = 0; alu_zero = 0;
    lsu_req_ready = 0; lsu_resp_valid = 0; lsu_rdata = 0;
    step();
    step();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_ifu_req_valid", ifu_req_valid, 1);
    chk("rst_inst", inst, 0);
    chk("rst_halt", halt, 0);
    chk("rst_retire", retire, 0);
    chk("rst_reg_wen", reg_wen, 0);
    chk("rst_lsu_req_valid", lsu_req_valid, 0);
    rst = 1;

    for (int i = 0; i < 10; i++) run_inst(vecs[i]);

`ifdef NPC_SEQ_MISALIGN_EN
    chk("misalign_halt", halt, 1);
    chk("misalign_err", misalign_err, 1);
`endif

    // Reset while a load is outstanding; the late LSU response must be ignored.
    rst = 0;
    step();
    rst = 1;
`ifdef NPC_SEQ_MISALIGN_EN
    chk("rst_misalign_err", misalign_err, 0);
`endif
    dec_npc_sel = 2'b00; dec_wdata_sel = 2'b11; dec_reg_wen = 1; dec_mem_ren = 1; dec_mem_wen = 0; dec_halt = 0;
    alu_result = 32'h8000_2000; lsu_rdata = 32'hCAFE_F00D; ifu_resp_inst = 32'h0005_2283;
    chk("mid_ifu_req_valid", ifu_req_valid, 1);
    ifu_req_ready = 1;
    step();
    ifu_req_ready = 0; ifu_resp_valid = 1;
    step();
    ifu_resp_valid = 0;
    step();
    chk("mid_lsu_req_valid", lsu_req_valid, 1);
    lsu_req_ready = 1;
    step();
    lsu_req_ready = 0;
    rst = 0;
    #1;
    chk("mid_rst_pc", pc, 32'h8000_0000);
    chk("mid_rst_ifu_req_valid", ifu_req_valid, 1);
    chk("mid_rst_lsu_req_valid", lsu_req_valid, 0);
    step();
    rst = 1;
    lsu_resp_valid = 1;
    step();
    lsu_resp_valid = 0;
    chk("late_resp_ifu_req_valid", ifu_req_valid, 1);
    chk("late_resp_retire", retire, 0);
    run_inst(mkv(2'b00, 2'b11, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0000_0013, 0, 1, 0, 1, 32'h8000_0000, 32'h0, 32'h8000_0004, 0, 4));

    // Halt instruction: pc still advances in WB, then nothing further is issued.
    run_inst(mkv(2'b00, 2'b00, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0010_0073, 0, 1, 0, 1, 32'h8000_0004, 32'h0, 32'h8000_0008, 0, 4));
    chk("halt_flag", halt, 1);
    dec_halt = 0;
    for (int i = 0; i < 6; i++) begin
      ifu_resp_valid = 1; lsu_resp_valid = 1; ifu_req_ready = 1; lsu_req_ready = 1;
      step();
      chk("halt_no_ifu_req", ifu_req_valid, 0);
    end
    ifu_resp_valid = 0; lsu_resp_valid = 0; ifu_req_ready = 0; lsu_req_ready = 0;
    chk("halt_no_lsu_req", lsu_req_valid, 0);
    chk("halt_pc_frozen", pc, 32'h8000_0008);
    chk("halt_sticky", halt, 1);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
